// File: rtl/lane_slice_pkg.sv
// rtl/lane_slice_pkg.sv - slice-mode constants, slicer states and beat/byte mapping helpers
package lane_slice_pkg;

    localparam logic MODE_CONTIG = 1'b0;
    localparam logic MODE_ILV    = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SLICE = 1'b1
    } slicer_state_t;

    function automatic int beats_of(input int in_w, input int link_w);
        return in_w / link_w;
    endfunction

    // Interleaved mode: byte j of beat k carries input byte j*beats+k.
    function automatic int ilv_byte_index(input int beat, input int lane_byte, input int beats);
        return lane_byte * beats + beat;
    endfunction

endpackage

// File: rtl/lane_slice_buffer_if.sv
// rtl/lane_slice_buffer_if.sv - word input, word output, fill status and beat tap bundle
interface lane_slice_buffer_if #(
    parameter int IN_W   = 64,
    parameter int LINK_W = 32,
    parameter int DEPTH  = 8
);
    localparam int FW = $clog2(DEPTH) + 1;

    logic [IN_W-1:0]   in_data;
    logic              in_mode;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   out_data;
    logic              out_valid;
    logic              out_ready;
    logic [FW-1:0]     fill_level;
    logic [LINK_W-1:0] tap_beat;
    logic              tap_en;

    modport master (
        output in_data, in_mode, in_valid, out_ready,
        input  in_ready, out_data, out_valid, fill_level, tap_beat, tap_en
    );

    modport slave (
        input  in_data, in_mode, in_valid, out_ready,
        output in_ready, out_data, out_valid, fill_level, tap_beat, tap_en
    );

endinterface

// File: rtl/lane_slice_ram.sv
// rtl/lane_slice_ram.sv - DEPTH x W beat store, synchronous write, combinational read
module lane_slice_ram #(
    parameter int W     = 33,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lane_slice_buffer.sv
// rtl/lane_slice_buffer.sv - slices words into link beats, buffers them, reassembles on output
module lane_slice_buffer
    import lane_slice_pkg::*;
#(
    parameter int IN_W   = 64,
    parameter int LINK_W = 32,
    parameter int DEPTH  = 8
) (
    input logic               clk,
    input logic               rst,
    lane_slice_buffer_if.slave bus
);

    localparam int BEATS = beats_of(IN_W, LINK_W);
    localparam int BPB   = LINK_W / 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [KW-1:0] K_LAST  = KW'(BEATS - 1);
    localparam logic [CW-1:0] C_BEATS = CW'(BEATS);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    slicer_state_t     state;
    logic [KW-1:0]     wk;
    logic [LINK_W-1:0] slice_in [BEATS];
    logic [LINK_W-1:0] beats_q  [BEATS];
    logic              mode_q;
    logic [CW-1:0]     credits;
    logic [CW-1:0]     credits_nxt;
    logic              credit_ok;
    logic              accept;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     fill;
    logic [LINK_W:0]   rd_entry;

    logic [KW-1:0]     rk;
    logic              rd_last;
    logic              rd_en;
    logic              pend;
    logic              out_busy;
    logic              out_free;
    logic [LINK_W-1:0] asm_q [BEATS];
    logic              asm_mode;
    logic [IN_W-1:0]   word_out;

    assign accept      = bus.in_valid && bus.in_ready;
    assign credits_nxt = credits + CW'(rd_en) - (accept ? C_BEATS : '0);
    assign credit_ok   = (credits_nxt >= C_BEATS);

    always_comb begin
        for (int b = 0; b < BEATS; b++) begin
            slice_in[b] = '0;
            for (int j = 0; j < BPB; j++) begin
                if (bus.in_mode == MODE_ILV)
                    slice_in[b][j*8 +: 8] = bus.in_data[ilv_byte_index(b, j, BEATS)*8 +: 8];
                else
                    slice_in[b][j*8 +: 8] = bus.in_data[(b*BPB + j)*8 +: 8];
            end
        end
    end

    // The whole word is sliced at accept time; tap_beat walks the latched beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            wk           <= '0;
            mode_q       <= MODE_CONTIG;
            bus.in_ready <= 1'b0;
            bus.tap_en   <= 1'b0;
            bus.tap_beat <= '0;
            for (int b = 0; b < BEATS; b++) beats_q[b] <= '0;
        end else if (accept) begin
            state        <= S_SLICE;
            wk           <= '0;
            mode_q       <= bus.in_mode;
            for (int b = 0; b < BEATS; b++) beats_q[b] <= slice_in[b];
            bus.tap_en   <= 1'b1;
            bus.tap_beat <= slice_in[0];
            bus.in_ready <= credit_ok && (K_LAST == '0);
        end else if (state == S_SLICE && wk != K_LAST) begin
            wk           <= wk + KW'(1);
            bus.tap_beat <= beats_q[wk + KW'(1)];
            bus.in_ready <= credit_ok && ((wk + KW'(1)) == K_LAST);
        end else begin
            state        <= S_IDLE;
            wk           <= '0;
            bus.tap_en   <= 1'b0;
            bus.tap_beat <= '0;
            bus.in_ready <= credit_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= C_DEPTH;
            fill    <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            credits <= credits_nxt;
            fill    <= fill + CW'(bus.tap_en) - CW'(rd_en);
            if (bus.tap_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en)      rd_ptr <= rd_ptr + AW'(1);
        end
    end

    assign bus.fill_level = fill;

    lane_slice_ram #(
        .W     (LINK_W + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.tap_en),
        .wr_addr (wr_ptr),
        .wr_data ({mode_q, bus.tap_beat}),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    // A new word is not started while the output is held, so back-pressure
    // leaves whole words in the buffer; the last beat needs a free output slot.
    assign rd_last  = (rk == K_LAST);
    assign out_busy = (bus.out_valid || pend) && !bus.out_ready;
    assign out_free = !pend && (!bus.out_valid || bus.out_ready);
    assign rd_en    = (fill != '0) && (rd_last ? out_free : ((rk != '0) || !out_busy));

    always_comb begin
        word_out = '0;
        for (int b = 0; b < BEATS; b++) begin
            for (int j = 0; j < BPB; j++) begin
                if (asm_mode == MODE_ILV)
                    word_out[ilv_byte_index(b, j, BEATS)*8 +: 8] = asm_q[b][j*8 +: 8];
                else
                    word_out[(b*BPB + j)*8 +: 8] = asm_q[b][j*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rk            <= '0;
            pend          <= 1'b0;
            asm_mode      <= MODE_CONTIG;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            for (int b = 0; b < BEATS; b++) asm_q[b] <= '0;
        end else begin
            if (rd_en) begin
                asm_q[rk] <= rd_entry[LINK_W-1:0];
                asm_mode  <= rd_entry[LINK_W];
                rk        <= rd_last ? '0 : rk + KW'(1);
            end
            pend <= rd_en && rd_last;
            if (pend) begin
                bus.out_data  <= word_out;
                bus.out_valid <= 1'b1;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lane_slice_buffer.sv
// tb/tb_lane_slice_buffer.sv - scoreboard bench with randomized words, modes and consumer stalls
module tb_lane_slice_buffer;
    import lane_slice_pkg::*;

    localparam int IN_W   = 64;
    localparam int LINK_W = 32;
    localparam int DEPTH  = 8;
    localparam int BEATS  = IN_W / LINK_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lane_slice_buffer_if #(.IN_W(IN_W), .LINK_W(LINK_W), .DEPTH(DEPTH)) bus ();

    lane_slice_buffer #(.IN_W(IN_W), .LINK_W(LINK_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_out   = 0;
    int acc_edge   = 0;
    int valid_edge = 0;
    logic              prev_valid = 1'b0;
    logic              hold_prev  = 1'b0;
    logic [IN_W-1:0]   hold_data  = '0;
    logic [IN_W-1:0]   last_out   = '0;
    logic [IN_W-1:0]   exp_q[$];
    logic [LINK_W-1:0] tap_exp_q[$];
    logic [LINK_W-1:0] tap_log[$];
    int                acc_edges[$];
    logic              stim_done = 1'b0;

    task automatic check(input string name, input logic [IN_W-1:0] got, input logic [IN_W-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: condition not met", name);
    endtask

    // Beat k of a word as the slicing rules define it.
    function automatic logic [LINK_W-1:0] model_beat(input logic [IN_W-1:0] w, input logic m, input int k);
        logic [LINK_W-1:0] r;
        r = '0;
        if (m == MODE_CONTIG) r = w[k*LINK_W +: LINK_W];
        else for (int j = 0; j < LINK_W/8; j++) r[j*8 +: 8] = w[ilv_byte_index(k, j, BEATS)*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            tap_exp_q.delete();
            hold_prev  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(bus.in_data);
                for (int k = 0; k < BEATS; k++) tap_exp_q.push_back(model_beat(bus.in_data, bus.in_mode, k));
                acc_edge = cyc + 1;
                acc_edges.push_back(cyc + 1);
            end
            if (bus.tap_en) begin
                tap_log.push_back(bus.tap_beat);
                if (tap_exp_q.size() == 0) fail_now("tap_unexpected");
                else check("tap_beat", bus.tap_beat, tap_exp_q.pop_front());
            end
            if (hold_prev) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, hold_data);
            end
            if (bus.out_valid && !prev_valid) valid_edge = cyc;
            if (bus.out_valid && bus.out_ready) begin
                last_out = bus.out_data;
                n_out++;
                if (exp_q.size() == 0) fail_now("out_unexpected");
                else check("out_data", bus.out_data, exp_q.pop_front());
            end
            if (bus.fill_level > DEPTH) fail_now("fill_bound");
            prev_valid = bus.out_valid;
            hold_prev  = bus.out_valid && !bus.out_ready;
            hold_data  = bus.out_data;
        end
    end

    task automatic send(input logic [IN_W-1:0] w, input logic m);
        int n;
        n = 0;
        bus.in_data  = w;
        bus.in_mode  = m;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) fail_now("send_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int target, input int budget);
        int n;
        n = 0;
        while (n_out < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n_out < target) fail_now("wait_out_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int base_out;
        logic acc;
        logic [IN_W-1:0] w;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_fill", bus.fill_level, 0);
        check("rst_tap_en", bus.tap_en, 0);
        check("rst_tap_beat", bus.tap_beat, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 check("in_ready_after_rst", bus.in_ready, 1);

        // single word, both slice modes
        bus.out_ready = 1'b1;
        for (int m = 0; m < 2; m++) begin
            tap_log.delete();
            base_out = n_out;
            send(64'h0807060504030201, 1'(m));
            bus.in_valid = 1'b0;
            wait_out(base_out + 1, 50);
            check("one_word_out", last_out, 64'h0807060504030201);
            check("latency", valid_edge - acc_edge, 4);
            if (tap_log.size() == 2) begin
                check("tap0", tap_log[0], (m == 0) ? 64'h04030201 : 64'h07050301);
                check("tap1", tap_log[1], (m == 0) ? 64'h08070605 : 64'h08060402);
            end else fail_now("tap_count");
        end

        // stalled consumer fills buffer plus output register
        bus.out_ready = 1'b0;
        base = acc_edges.size();
        base_out = n_out;
        bus.in_data  = {$urandom, $urandom};
        bus.in_mode  = 1'($urandom_range(0, 1));
        bus.in_valid = 1'b1;
        repeat (40) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                bus.in_data = {$urandom, $urandom};
                bus.in_mode = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        check("stall_words", acc_edges.size() - base, 5);
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_fill", bus.fill_level, 8);
        check("stall_out_valid", bus.out_valid, 1);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_out(base_out + 5, 100);
        check("stall_drained", exp_q.size(), 0);

        // back-to-back alternating modes
        base = acc_edges.size();
        base_out = n_out;
        for (int i = 0; i < 4; i++) send({$urandom, $urandom}, 1'(i % 2));
        bus.in_valid = 1'b0;
        wait_out(base_out + 4, 50);
        for (int i = 0; i < 3; i++) check("b2b_spacing", acc_edges[base+i+1] - acc_edges[base+i], 2);

        // random words and modes against a 50% stalling consumer
        base_out = n_out;
        stim_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    send({$urandom, $urandom}, 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) begin
                        bus.in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                bus.in_valid = 1'b0;
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_out(base_out + 200, 3000);
        check("random_drained", exp_q.size(), 0);

        // reset while the second beat is written and the output is held
        bus.out_ready = 1'b0;
        base_out = n_out;
        send({$urandom, $urandom}, 1'b0);
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_out_valid", bus.out_valid, 1);
        send({$urandom, $urandom}, 1'b1);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_tap_en", bus.tap_en, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_fill", bus.fill_level, 0);
        check("mid_rst_tap_en", bus.tap_en, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        w = {$urandom, $urandom};
        base_out = n_out;
        send(w, 1'b1);
        bus.in_valid = 1'b0;
        wait_out(base_out + 1, 50);
        check("post_rst_word", last_out, w);
        check("post_rst_count", n_out - base_out, 1);
        check("final_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
